// File: rtl/wireframe_buffer_pkg.sv
// rtl/wireframe_buffer_pkg.sv - shared types and default geometry for the wireframe frame store
// Purpose: FSM state type and default frame geometry used by wireframe_buffer and its bench.
package wireframe_buffer_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_HEIGHT = 4;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SCAN  = 2'd2
    } wfb_state_t;

endpackage

// File: rtl/wf_mem.sv
// rtl/wf_mem.sv - 1-bit simple dual-port frame RAM with a registered read port
// Purpose: pixel storage; one write port, one read port whose data appears the cycle after i_re.
// Ports:
//   clk              clock, rising edge
//   i_we/i_waddr/i_wdata   write strobe, address, data
//   i_re/i_raddr     read strobe and address
//   o_rdata          registered read data
module wf_mem #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic              i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic              o_rdata
);

    logic r_mem [0:(2**ADDR_W)-1];
    logic r_rdata;

    // Contents are deliberately not reset; the owner bulk-clears before use.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wireframe_buffer.sv
// rtl/wireframe_buffer.sv - 1-bit wireframe frame store with bulk clear and raster-order readout
// Purpose: captures rasterizer pixel writes, clears the frame one address per cycle, and streams the
//          frame out in raster order over pix_valid/pix_ready.
// Ports:
//   clk, n_rst                    clock, asynchronous active-low reset
//   write_en, wf_data, addr       pixel write (accepted only in IDLE with addr < WIDTH*HEIGHT)
//   clear, scan_start             commands, sampled only in IDLE (clear has priority)
//   busy, clear_done, wr_drop     status: CLEAR/SCAN active, clear finished pulse, sticky dropped write
//   pix_valid, pix_ready          readout handshake
//   pix_data, pix_x, pix_y        readout pixel and its coordinates
//   frame_end                     marks the last pixel of the frame
module wireframe_buffer
    import wireframe_buffer_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       write_en,
    input  logic                       wf_data,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       clear,
    input  logic                       scan_start,
    output logic                       busy,
    output logic                       clear_done,
    output logic                       wr_drop,
    output logic                       pix_valid,
    input  logic                       pix_ready,
    output logic                       pix_data,
    output logic [$clog2(WIDTH)-1:0]   pix_x,
    output logic [$clog2(HEIGHT)-1:0]  pix_y,
    output logic                       frame_end
);

    localparam int X_W = $clog2(WIDTH);
    localparam int Y_W = $clog2(HEIGHT);
    localparam int unsigned NUM_PIXELS = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [X_W-1:0]    LAST_X    = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]    LAST_Y    = Y_W'(HEIGHT - 1);

    wfb_state_t        r_state;
    logic              r_busy, r_clear_done, r_wr_drop;
    logic [ADDR_W-1:0] r_clr_addr, r_rd_addr;
    logic [X_W-1:0]    r_iss_x, r_s1_x, r_out_x, r_skid_x;
    logic [Y_W-1:0]    r_iss_y, r_s1_y, r_out_y, r_skid_y;
    logic              r_iss_done;
    logic              r_s1_valid, r_s1_last;
    logic              r_out_valid, r_out_data, r_out_last;
    logic              r_skid_valid, r_skid_data, r_skid_last;

    logic              w_clearing, w_in_range, w_wr_ok, w_wr_drop;
    logic              w_we, w_wdata, w_rd_data;
    logic [ADDR_W-1:0] w_waddr;
    logic              w_pop, w_iss_last, w_room, w_issue;
    logic [1:0]        w_occ;

    assign w_clearing = (r_state == CLEAR);
    assign w_in_range = ({{(32-ADDR_W){1'b0}}, addr} < NUM_PIXELS);
    assign w_wr_ok    = write_en && (r_state == IDLE) && w_in_range;
    assign w_wr_drop  = write_en && !((r_state == IDLE) && w_in_range);

    assign w_we    = w_clearing || w_wr_ok;
    assign w_waddr = w_clearing ? r_clr_addr : addr;
    assign w_wdata = w_clearing ? 1'b0 : wf_data;

    // Pixels in flight: the RAM output stage plus the two skid slots. A read is issued only if,
    // after this cycle's pop, at most one slot is taken, so the pixel arriving next always fits.
    assign w_pop      = r_out_valid && pix_ready;
    assign w_occ      = {1'b0, r_out_valid} + {1'b0, r_skid_valid} + {1'b0, r_s1_valid};
    assign w_room     = (w_occ <= (2'd1 + {1'b0, w_pop}));
    assign w_iss_last = (r_iss_x == LAST_X) && (r_iss_y == LAST_Y);
    assign w_issue    = (r_state == SCAN) && !r_iss_done && w_room;

    wf_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_issue),
        .i_raddr (r_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_clear_done <= 1'b0;
            r_wr_drop    <= 1'b0;
            r_clr_addr   <= '0;
            r_rd_addr    <= '0;
            r_iss_x      <= '0;
            r_iss_y      <= '0;
            r_iss_done   <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            if (w_wr_drop) begin
                r_wr_drop <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (clear) begin
                        r_state    <= CLEAR;
                        r_busy     <= 1'b1;
                        r_clr_addr <= '0;
                        r_wr_drop  <= 1'b0;
                    end else if (scan_start) begin
                        r_state    <= SCAN;
                        r_busy     <= 1'b1;
                        r_rd_addr  <= '0;
                        r_iss_x    <= '0;
                        r_iss_y    <= '0;
                        r_iss_done <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (r_clr_addr == LAST_ADDR) begin
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                        r_clear_done <= 1'b1;
                    end else begin
                        r_clr_addr <= r_clr_addr + ADDR_W'(1);
                    end
                end
                SCAN: begin
                    if (w_issue) begin
                        if (w_iss_last) begin
                            r_iss_done <= 1'b1;
                        end else begin
                            r_rd_addr <= r_rd_addr + ADDR_W'(1);
                            if (r_iss_x == LAST_X) begin
                                r_iss_x <= '0;
                                r_iss_y <= r_iss_y + Y_W'(1);
                            end else begin
                                r_iss_x <= r_iss_x + X_W'(1);
                            end
                        end
                    end
                    if (w_pop && r_out_last) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // RAM output stage tags, then a two-slot output/skid queue in front of the consumer.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_x       <= '0;
            r_s1_y       <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= 1'b0;
            r_skid_last  <= 1'b0;
            r_skid_x     <= '0;
            r_skid_y     <= '0;
        end else begin
            r_s1_valid <= w_issue;
            r_s1_last  <= w_issue && w_iss_last;
            if (w_issue) begin
                r_s1_x <= r_iss_x;
                r_s1_y <= r_iss_y;
            end
            if (!r_out_valid || w_pop) begin
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_skid_data;
                    r_out_last   <= r_skid_last;
                    r_out_x      <= r_skid_x;
                    r_out_y      <= r_skid_y;
                    r_skid_valid <= r_s1_valid;
                    r_skid_data  <= w_rd_data;
                    r_skid_last  <= r_s1_valid && r_s1_last;
                    r_skid_x     <= r_s1_x;
                    r_skid_y     <= r_s1_y;
                end else begin
                    r_out_valid <= r_s1_valid;
                    r_out_data  <= w_rd_data;
                    r_out_last  <= r_s1_valid && r_s1_last;
                    r_out_x     <= r_s1_x;
                    r_out_y     <= r_s1_y;
                end
            end else if (r_s1_valid) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= w_rd_data;
                r_skid_last  <= r_s1_last;
                r_skid_x     <= r_s1_x;
                r_skid_y     <= r_s1_y;
            end
        end
    end

    assign busy       = r_busy;
    assign clear_done = r_clear_done;
    assign wr_drop    = r_wr_drop;
    assign pix_valid  = r_out_valid;
    assign pix_data   = r_out_data;
    assign pix_x      = r_out_x;
    assign pix_y      = r_out_y;
    assign frame_end  = r_out_last;

endmodule

// File: tb/tb_wireframe_buffer.sv
// tb/tb_wireframe_buffer.sv - self-checking bench for wireframe_buffer against a raster frame model
module tb_wireframe_buffer;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 6;
    localparam int NP = W * H;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          write_en, wf_data, clear, scan_start, pix_ready;
    logic [AW-1:0] addr;
    logic          busy, clear_done, wr_drop, pix_valid, pix_data, frame_end;
    logic [2:0]    pix_x;
    logic [1:0]    pix_y;

    int   checks = 0;
    int   errors = 0;
    bit   mdl [NP];
    bit   mdl_drop;
    logic cap [NP];
    int   mon_idx;
    bit   mon_active;
    logic [3:0] tog = 4'b1001;

    logic p_valid, p_ready, p_data, p_fe;
    logic [2:0] p_x;
    logic [1:0] p_y;

    wireframe_buffer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk(clk), .n_rst(n_rst), .write_en(write_en), .wf_data(wf_data), .addr(addr),
        .clear(clear), .scan_start(scan_start), .busy(busy), .clear_done(clear_done),
        .wr_drop(wr_drop), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare: accepted pixels must follow raster order with the model's contents,
    // and a stalled pixel must not change.
    always @(negedge clk) begin
        if (!n_rst) begin
            p_valid = 1'b0;
        end else begin
            if (p_valid && !p_ready) begin
                chk("hold_valid", pix_valid, 1);
                chk("hold_data", pix_data, p_data);
                chk("hold_xy", {pix_y, pix_x}, {p_y, p_x});
                chk("hold_fe", frame_end, p_fe);
            end
            if (!mon_active) chk("stray_valid", pix_valid, 0);
            if (!pix_valid) chk("fe_without_valid", frame_end, 0);
            if (pix_valid && pix_ready && mon_active) begin
                if (mon_idx >= NP) begin
                    chk("extra_pixel", mon_idx, NP - 1);
                end else begin
                    chk("pix_x", pix_x, mon_idx % W);
                    chk("pix_y", pix_y, mon_idx / W);
                    chk("pix_data", pix_data, mdl[mon_idx]);
                    chk("frame_end", frame_end, (mon_idx == NP - 1) ? 1 : 0);
                    cap[mon_idx] = pix_data;
                end
                mon_idx++;
            end
            p_valid = pix_valid; p_ready = pix_ready; p_data = pix_data;
            p_fe = frame_end; p_x = pix_x; p_y = pix_y;
        end
    end

    task automatic all_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_clear_done"}, clear_done, 0);
        chk({nm, "_wr_drop"}, wr_drop, 0);
        chk({nm, "_pix_valid"}, pix_valid, 0);
        chk({nm, "_pix_data"}, pix_data, 0);
        chk({nm, "_pix_xy"}, {pix_y, pix_x}, 0);
        chk({nm, "_frame_end"}, frame_end, 0);
    endtask

    task automatic wr(input int a, input bit d);
        @(posedge clk); #1;
        write_en = 1'b1; addr = AW'(a); wf_data = d;
        @(posedge clk); #1;
        write_en = 1'b0;
        if (a < NP) mdl[a] = d;
        else mdl_drop = 1'b1;
        chk("wr_drop_after_write", wr_drop, mdl_drop);
    endtask

    task automatic do_clear(input bit with_scan, input bit inject);
        int  cnt;
        bit  fin;
        cnt = 0; fin = 0;
        @(posedge clk); #1;
        clear = 1'b1; scan_start = with_scan;
        @(posedge clk); #1;
        clear = 1'b0; scan_start = 1'b0;
        for (int c = 0; c < 100 && !fin; c++) begin
            write_en = inject && (c == 5); addr = 3; wf_data = 1'b1;
            @(negedge clk); #1;
            if (busy) cnt++;
            else begin
                chk("clear_done_pulse", clear_done, 1);
                fin = 1;
            end
            @(posedge clk); #1;
        end
        write_en = 1'b0;
        chk("clear_finished", fin, 1);
        chk("clear_busy_cycles", cnt, NP);
        @(negedge clk); #1;
        chk("clear_done_one_cycle", clear_done, 0);
        for (int i = 0; i < NP; i++) mdl[i] = 1'b0;
        mdl_drop = inject;
        chk("wr_drop_after_clear", wr_drop, mdl_drop);
    endtask

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return tog[c % 4];
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_scan(input int mode, input bit inject);
        int first, last, vc;
        bit done;
        first = -1; last = -1; vc = 0; done = 0;
        mon_idx = 0; mon_active = 1'b1;
        for (int i = 0; i < NP; i++) cap[i] = 1'bx;
        @(posedge clk); #1;
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        chk("scan_busy", busy, 1);
        for (int c = 0; c < 600 && !done; c++) begin
            pix_ready = ready_for(mode, c);
            scan_start = inject && (c == 12);
            @(negedge clk); #1;
            if (c < 2) chk("latency_low", pix_valid, 0);
            if (c == 2) chk("latency_first", pix_valid, 1);
            if (pix_valid) begin
                vc++;
                if (first < 0) first = c;
                last = c;
            end
            if (mon_idx == NP) done = 1;
            @(posedge clk); #1;
        end
        scan_start = 1'b0;
        chk("scan_done", done, 1);
        chk("scan_count", mon_idx, NP);
        chk("exit_valid", pix_valid, 0);
        chk("exit_busy", busy, 0);
        if (mode == 0) begin
            chk("valid_cycles", vc, NP);
            chk("valid_span", last - first + 1, NP);
        end
        mon_active = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        n_rst = 1'b0; write_en = 1'b0; wf_data = 1'b0; addr = '0; clear = 1'b0;
        scan_start = 1'b0; pix_ready = 1'b0; mon_active = 1'b0; mon_idx = 0; mdl_drop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        all_zero("in_reset");
        @(negedge clk); #1;
        n_rst = 1'b1;
        @(negedge clk); #1;
        all_zero("after_reset");

        // 1: clear then all-zero frame
        do_clear(0, 0);
        do_scan(0, 0);

        // 2: sparse writes, full-rate readout, literal pins on the captured frame
        wr(0, 1); wr(9, 1); wr(31, 1);
        do_scan(0, 0);
        chk("lit_pix_0_0", cap[0], 1);
        chk("lit_pix_1_1", cap[9], 1);
        chk("lit_pix_7_3", cap[31], 1);
        chk("lit_pix_0_1", cap[8], 0);
        chk("lit_pix_1_0", cap[1], 0);

        // 3 + 5b: ready pattern 1,0,0,1 with a scan_start issued mid-scan
        do_scan(1, 1);

        // 4: out-of-range write, then a write during CLEAR
        wr(32, 1);
        chk("lit_drop_oor", wr_drop, 1);
        do_clear(0, 1);
        chk("lit_drop_in_clear", wr_drop, 1);
        do_scan(0, 0);
        chk("lit_addr3_clear", cap[3], 0);

        // 5: clear and scan_start together -> clear wins, no readout
        do_clear(1, 0);
        chk("lit_drop_cleared", wr_drop, 0);

        // randomized writes and backpressure
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < 20; n++) begin
                wr(int'($urandom_range(0, 47)), 1'($urandom_range(0, 1)));
            end
            do_scan(2, 0);
            if (r == 1) do_clear(0, 0);
        end
        for (int n = 0; n < 12; n++) wr(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));

        // 6: reset after 10 pixels, then a fresh scan from (0,0)
        mon_idx = 0; mon_active = 1'b1; pix_ready = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk); #1;
            if (mon_idx >= 10) ok = 1;
        end
        chk("reached_10_pixels", ok, 1);
        #2;
        n_rst = 1'b0;
        mon_active = 1'b0;
        #1;
        all_zero("async_reset");
        @(posedge clk); #1;
        @(negedge clk); #1;
        n_rst = 1'b1;
        mdl_drop = 1'b0;
        @(negedge clk); #1;
        all_zero("after_mid_reset");
        do_scan(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
